// File: rtl/demod_segment_scheduler.sv
// Round-robin scheduler sharing one fixed-latency demodulation segment stage between
// NUM_REQ requesters; holds start until valid, releases for one cycle, aborts on watchdog.
module demod_segment_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 2,
   parameter int SEG_LAT = 3,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [DATA_W-1:0]         seg_input_bit,
   output logic                      seg_start,
   input  logic                      seg_valid,
   output logic                      done,
   output logic                      err,
   output logic [ID_W-1:0]           done_id,
   output logic                      busy
);

   // Never let the watchdog fire before a healthy stage could have answered.
   localparam int WD_LIMIT = (TIMEOUT > SEG_LAT + 1) ? TIMEOUT : SEG_LAT + 2;
   localparam int WD_W     = $clog2(WD_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_RELEASE
   } state_e;

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     cur_id_q, cur_id_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [DATA_W-1:0]   seg_data_q, seg_data_d;
   logic                seg_start_q, seg_start_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [ID_W-1:0]     done_id_q, done_id_d;
   logic                busy_q, busy_d;

   logic                found;
   logic [ID_W-1:0]     idx;
   logic [ID_W-1:0]     winner;
   logic [DATA_W-1:0]   win_word;

   // Rotating priority search starting at rr_ptr_q.
   always_comb begin
      found    = 1'b0;
      idx      = '0;
      winner   = '0;
      win_word = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == ID_W'(i)) win_word = req_data[i*DATA_W +: DATA_W];
      end
   end

   // NOTE: every combinational output gets a default before the case, so no path
   // through the block leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cur_id_d    = cur_id_q;
      wd_d        = wd_q;
      gnt_d       = '0;
      seg_data_d  = seg_data_q;
      seg_start_d = seg_start_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      done_id_d   = done_id_q;
      busy_d      = busy_q;

      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               gnt_d       = NUM_REQ'(1) << winner;
               seg_data_d  = win_word;
               cur_id_d    = winner;
               rr_ptr_d    = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
               wd_d        = '0;
               seg_start_d = 1'b1;
               busy_d      = 1'b1;
               state_d     = S_RUN;
            end
         end
         S_RUN: begin
            // Valid wins over the watchdog when both happen in the same cycle.
            if (seg_valid) begin
               done_d      = 1'b1;
               done_id_d   = cur_id_q;
               seg_start_d = 1'b0;
               state_d     = S_RELEASE;
            end else if (wd_q == WD_W'(WD_LIMIT - 1)) begin
               err_d       = 1'b1;
               done_id_d   = cur_id_q;
               seg_start_d = 1'b0;
               state_d     = S_RELEASE;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_RELEASE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         cur_id_q    <= '0;
         wd_q        <= '0;
         gnt_q       <= '0;
         seg_data_q  <= '0;
         seg_start_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         done_id_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cur_id_q    <= cur_id_d;
         wd_q        <= wd_d;
         gnt_q       <= gnt_d;
         seg_data_q  <= seg_data_d;
         seg_start_q <= seg_start_d;
         done_q      <= done_d;
         err_q       <= err_d;
         done_id_q   <= done_id_d;
         busy_q      <= busy_d;
      end
   end

   assign gnt           = gnt_q;
   assign seg_input_bit = seg_data_q;
   assign seg_start     = seg_start_q;
   assign done          = done_q;
   assign err           = err_q;
   assign done_id       = done_id_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_demod_segment_scheduler.sv
// Bench for demod_segment_scheduler: job-timeline reference model plus a fixed-latency
// stage model, directed scenarios followed by random request traffic.
module tb_demod_segment_scheduler;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 32;
   localparam int ID_W    = 2;
   localparam int SEG_LAT = 3;
   localparam int TIMEOUT = 16;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        gnt;
   logic [DATA_W-1:0]         seg_input_bit;
   logic                      seg_start;
   logic                      seg_valid;
   logic                      done;
   logic                      err;
   logic [ID_W-1:0]           done_id;
   logic                      busy;

   demod_segment_scheduler #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W), .SEG_LAT(SEG_LAT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
      .seg_input_bit(seg_input_bit), .seg_start(seg_start), .seg_valid(seg_valid),
      .done(done), .err(err), .done_id(done_id), .busy(busy)
   );

   always #5 clk = ~clk;

   // Shared stage: valid after SEG_LAT clocks of start; mode 1 never answers, mode 2 stuck high.
   int stage_mode = 0;
   int stage_cnt;
   always @(posedge clk or posedge reset) begin
      if (reset)                 stage_cnt <= 0;
      else if (!seg_start)       stage_cnt <= 0;
      else if (stage_cnt < SEG_LAT) stage_cnt <= stage_cnt + 1;
   end
   assign seg_valid = (stage_mode == 2) || (stage_mode == 0 && seg_start && stage_cnt == SEG_LAT);

   // Reference model: one job described by the cycle of its grant and of its done/err.
   bit                 job;
   logic [ID_W-1:0]    job_id;
   logic [DATA_W-1:0]  job_word;
   bit                 job_err;
   int                 g_cyc, e_cyc;
   int                 rr;
   int                 cyc;
   bit                 rand_en;
   int                 vectors, miscompares;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic post_req(input int i, input logic [DATA_W-1:0] w);
      req[i] = 1'b1;
      req_data[i*DATA_W +: DATA_W] = w;
   endtask

   task automatic check_cycle();
      logic [NUM_REQ-1:0] e_gnt;
      bit in_job;
      in_job = job && cyc >= g_cyc && cyc <= e_cyc;
      e_gnt  = (job && cyc == g_cyc) ? (NUM_REQ'(1) << job_id) : '0;
      check("gnt", 64'(gnt), 64'(e_gnt));
      check("seg_start", 64'(seg_start), 64'(in_job && cyc < e_cyc));
      check("busy", 64'(busy), 64'(in_job));
      check("done", 64'(done), 64'(job && cyc == e_cyc && !job_err));
      check("err", 64'(err), 64'(job && cyc == e_cyc && job_err));
      if (in_job && cyc < e_cyc) check("seg_input_bit", 64'(seg_input_bit), 64'(job_word));
      if (job && cyc == e_cyc) check("done_id", 64'(done_id), 64'(job_id));
   endtask

   // One clock cycle: check outputs, let requesters react, arbitrate in the model.
   task automatic step();
      check_cycle();
      if (job && cyc == g_cyc) req[job_id] = 1'b0;
      if (job && cyc > e_cyc) job = 1'b0;
      if (rand_en) begin
         int ri;
         ri = int'($urandom_range(NUM_REQ - 1));
         if (!req[ri] && $urandom_range(3) == 0) post_req(ri, $urandom);
      end
      if (!job && req != '0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (rr + k) % NUM_REQ;
            if (!job && req[c]) begin
               job      = 1'b1;
               job_id   = ID_W'(c);
               job_word = req_data[c*DATA_W +: DATA_W];
               job_err  = (stage_mode == 1);
               g_cyc    = cyc + 1;
               e_cyc    = job_err ? g_cyc + TIMEOUT : g_cyc + SEG_LAT + 1;
               rr       = (c + 1) % NUM_REQ;
            end
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_gnt", 64'(gnt), 64'(0));
      check("rst_seg_start", 64'(seg_start), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_seg_input_bit", 64'(seg_input_bit), 64'(0));
      check("rst_done_id", 64'(done_id), 64'(0));
      job = 1'b0;
      rr  = 0;
      req = '0;
      @(negedge clk);
      cyc++;
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      req      = '0;
      req_data = '0;
      vectors  = 0;
      miscompares = 0;
      job = 1'b0; rr = 0; cyc = 0; rand_en = 1'b0;
      @(negedge clk);
      do_reset();

      // Single request from requester 2.
      post_req(2, 32'hA5A5_0002);
      run(8);

      // All four held from rr_ptr=0: grants 0,1,2,3 six cycles apart, pointer wraps.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) post_req(i, 32'hC0DE_0000 + 32'(i));
      run(28);

      // Move pointer to 1 via requester 0, then 4'b1001 -> 3 then 0.
      post_req(0, 32'h1111_0000);
      run(8);
      post_req(0, 32'h2222_0000);
      post_req(3, 32'h3333_0003);
      run(16);

      // Stage never answers: watchdog abort.
      stage_mode = 1;
      post_req(1, 32'hDEAD_0001);
      run(TIMEOUT + 5);
      stage_mode = 0;

      // Reset in the third RUN cycle kills the job; pointer restarts at 0.
      post_req(2, 32'hBEEF_0002);
      run(3);
      do_reset();
      run(6);
      post_req(0, 32'h0000_00A0);
      post_req(3, 32'h0000_00A3);
      run(16);

      // Valid stuck high while idle is ignored; a later job still runs normally.
      stage_mode = 2;
      run(5);
      stage_mode = 0;
      post_req(1, 32'h5555_0001);
      run(8);

      // Random traffic, then drain.
      rand_en = 1'b1;
      run(800);
      rand_en = 1'b0;
      run(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
